// File: rtl/vector_serializer.sv
// Ring buffer of 8-bit vectors served one bit per request, MSB first.
// Pairs with the receive-side buffer that shifts left and appends at the LSB.
module vector_serializer #(
    parameter int nb_vectors = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    vector,
    input  logic                          vector_valid,
    output logic                          vector_ready,
    output logic [$clog2(nb_vectors):0]   count,
    input  logic                          bit_req,
    output logic                          bit_out,
    output logic                          bit_valid
);

    localparam int PW = $clog2(nb_vectors);
    localparam int CW = PW + 1;

    logic [7:0]    buffer [nb_vectors];
    logic [PW-1:0] prod;
    logic [PW-1:0] cons;
    logic [2:0]    idx;
    logic          enq;
    logic          srv;
    logic          done;

    assign vector_ready = (count != CW'(nb_vectors));
    assign enq  = vector_valid && vector_ready;
    assign srv  = bit_req && (count != '0);
    assign done = srv && (idx == 3'd7);

    // Storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            buffer[prod] <= vector;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod      <= '0;
            cons      <= '0;
            idx       <= '0;
            count     <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end else begin
            if (enq) begin
                prod <= prod + 1'b1;
            end
            if (srv) begin
                bit_out   <= buffer[cons][3'd7 - idx];
                bit_valid <= 1'b1;
                idx       <= idx + 3'd1;
                if (idx == 3'd7) begin
                    cons <= cons + 1'b1;
                end
            end else begin
                bit_out   <= 1'b0;
                bit_valid <= 1'b0;
            end
            unique case ({enq, done})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_serializer.sv
// Scoreboard bench for vector_serializer: accepted vectors queue their
// expected bits, a negedge monitor pops and compares each served bit.
module tb_vector_serializer;

    logic       clk;
    logic       rst_n;
    logic [7:0] vector;
    logic       vector_valid;
    logic       vector_ready;
    logic [3:0] count;
    logic       bit_req;
    logic       bit_out;
    logic       bit_valid;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_q[$];

    vector_serializer #(.nb_vectors(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vector       (vector),
        .vector_valid (vector_valid),
        .vector_ready (vector_ready),
        .count        (count),
        .bit_req      (bit_req),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v, input bit acc);
        check("ready_before_push", int'(vector_ready), int'(acc));
        vector       = v;
        vector_valid = 1'b1;
        if (acc) begin
            for (int b = 7; b >= 0; b--) exp_q.push_back(v[b]);
        end
        tick();
        vector_valid = 1'b0;
    endtask

    task automatic req(input int n);
        bit_req = 1'b1;
        repeat (n) tick();
        bit_req = 1'b0;
    endtask

    // Monitor: every presented bit must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bit_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL extra_bit: got %0d expected none", bit_out);
            end else begin
                check("bit_out", int'(bit_out), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        bit rdy_ok;
        rst_n        = 1'b0;
        vector       = '0;
        vector_valid = 1'b0;
        bit_req      = 1'b0;

        // 1: reset
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_ready", int'(vector_ready), 1);
        check("rst_count", int'(count), 0);
        check("rst_valid", int'(bit_valid), 0);
        check("rst_bit", int'(bit_out), 0);

        // 2: single vector 0xA5, then a request on empty
        push(8'hA5, 1'b1);
        check("a5_count", int'(count), 1);
        req(8);
        check("a5_count_done", int'(count), 0);
        bit_req = 1'b1;
        tick();
        bit_req = 1'b0;
        check("empty_req_valid", int'(bit_valid), 0);
        check("empty_req_bit", int'(bit_out), 0);
        check("a5_drained", exp_q.size(), 0);

        // 3: fill ring, overflow push dropped, drain in order
        for (int i = 0; i < 8; i++) push(8'(i), 1'b1);
        check("full_count", int'(count), 8);
        check("full_ready", int'(vector_ready), 0);
        push(8'hFF, 1'b0);
        check("full_count_after_ff", int'(count), 8);
        req(64);
        tick();
        check("full_drained_count", int'(count), 0);
        check("full_drained_q", exp_q.size(), 0);

        // 4: alternating requests on 0x3C
        push(8'h3C, 1'b1);
        for (int i = 0; i < 16; i++) begin
            bit_req = (i % 2 == 0);
            tick();
            if (i % 2 == 1) check("gap_valid", int'(bit_valid), 0);
        end
        bit_req = 1'b0;
        tick();
        check("alt_count", int'(count), 0);
        check("alt_q", exp_q.size(), 0);

        // 5: streaming 20 vectors with continuous requests
        rdy_ok  = 1'b1;
        bit_req = 1'b1;
        for (int c = 0; c < 170; c++) begin
            vector_valid = (c % 8 == 0) && (c / 8 < 20);
            vector       = 8'(8'h10 + c / 8);
            if (vector_valid) begin
                if (!vector_ready) rdy_ok = 1'b0;
                for (int b = 7; b >= 0; b--) exp_q.push_back(vector[b]);
            end
            tick();
        end
        vector_valid = 1'b0;
        bit_req      = 1'b0;
        tick();
        check("stream_ready", int'(rdy_ok), 1);
        check("stream_count", int'(count), 0);
        check("stream_q", exp_q.size(), 0);

        // 6: reset mid-vector discards everything
        push(8'hF0, 1'b1);
        push(8'h0F, 1'b1);
        req(3);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_count", int'(count), 0);
        check("midrst_valid", int'(bit_valid), 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        push(8'h81, 1'b1);
        req(8);
        tick();
        check("post_rst_count", int'(count), 0);
        check("post_rst_q", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
